// File: rtl/lv_scan_reg_bist_pkg.sv
// Shared constants and FSM state type for the LV scan-register BIST responder.
// The controller and the register file see the same register count and base address.
package lv_bist_pkg;

    localparam int unsigned LV_SCAN_REG_NUM = 8;
    localparam int unsigned REG_DW          = 8;
    localparam int unsigned REG_AW          = 8;
    localparam logic [7:0]  SCAN_BASE_ADDR  = 8'h40;
    localparam logic [7:0]  BIST_PAT0       = 8'h55;
    localparam logic [7:0]  BIST_PAT1       = 8'hAA;

    typedef enum logic [2:0] {
        IDLE,
        RD_ORIG,
        WR_P0,
        RD_P0,
        WR_P1,
        RD_P1,
        RESTORE,
        ACK
    } state_e;

endpackage

// File: rtl/lv_scan_reg_bist_if.sv
// Request/ack handshake with the BIST controller plus the LV register-file bus.
// The slave modport is the BIST responder; the master modport is the surrounding logic.
interface lv_scan_reg_bist_if
    import lv_bist_pkg::*;
#(
    parameter int unsigned AW = REG_AW,
    parameter int unsigned DW = REG_DW
);

    logic          i_bist_scan_reg_req;
    logic          o_scan_reg_bist_ack;
    logic          o_scan_reg_bist_err;
    logic [AW-1:0] o_reg_addr;
    logic          o_reg_rd_en;
    logic          o_reg_wr_en;
    logic [DW-1:0] o_reg_wdata;
    logic [DW-1:0] i_reg_rdata;

    modport slave (
        input  i_bist_scan_reg_req,
        input  i_reg_rdata,
        output o_scan_reg_bist_ack,
        output o_scan_reg_bist_err,
        output o_reg_addr,
        output o_reg_rd_en,
        output o_reg_wr_en,
        output o_reg_wdata
    );

    modport master (
        output i_bist_scan_reg_req,
        output i_reg_rdata,
        input  o_scan_reg_bist_ack,
        input  o_scan_reg_bist_err,
        input  o_reg_addr,
        input  o_reg_rd_en,
        input  o_reg_wr_en,
        input  o_reg_wdata
    );

endinterface

// File: rtl/lv_scan_reg_bist.sv
// Tests one LV scan register per request: save, write/read 0x55 and 0xAA, restore, ack.
// Dropping the BIST enable mid-test always puts the saved value back before going idle.
module lv_scan_reg_bist #(
    parameter int unsigned LV_SCAN_REG_NUM = lv_bist_pkg::LV_SCAN_REG_NUM,
    parameter int unsigned REG_DW          = lv_bist_pkg::REG_DW,
    parameter int unsigned REG_AW          = lv_bist_pkg::REG_AW,
    parameter logic [REG_AW-1:0] SCAN_BASE_ADDR = REG_AW'(lv_bist_pkg::SCAN_BASE_ADDR),
    parameter logic [REG_DW-1:0] BIST_PAT0      = REG_DW'(lv_bist_pkg::BIST_PAT0),
    parameter logic [REG_DW-1:0] BIST_PAT1      = REG_DW'(lv_bist_pkg::BIST_PAT1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_bist_en,
    output logic                     o_bist_busy,
    output logic                     o_bist_done,
    lv_scan_reg_bist_if.slave        bus
);
    import lv_bist_pkg::*;

    localparam int unsigned          PTR_W   = $clog2(LV_SCAN_REG_NUM + 1);
    localparam logic [PTR_W-1:0]     PTR_END = PTR_W'(LV_SCAN_REG_NUM);

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q;
    logic [REG_DW-1:0]   orig_q;
    logic [REG_DW-1:0]   wdata_d;
    logic                err_acc_q;
    logic                abort_q;
    logic                abort_now;

    assign abort_now = !i_bist_en && (state_q inside {WR_P0, RD_P0, WR_P1, RD_P1});

    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: next state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_bist_en && bus.i_bist_scan_reg_req && (ptr_q < PTR_END)) state_d = RD_ORIG;
            RD_ORIG: state_d = i_bist_en ? WR_P0 : IDLE;
            WR_P0:   state_d = i_bist_en ? RD_P0 : RESTORE;
            RD_P0:   state_d = i_bist_en ? WR_P1 : RESTORE;
            WR_P1:   state_d = i_bist_en ? RD_P1 : RESTORE;
            RD_P1:   state_d = RESTORE;
            RESTORE: state_d = (i_bist_en && !abort_q) ? ACK : IDLE;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // abort_q remembers that RESTORE was entered to undo a pattern, not to finish a test.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q     <= '0;
            orig_q    <= '0;
            err_acc_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    abort_q <= 1'b0;
                    if (!i_bist_en) begin
                        ptr_q     <= '0;
                        err_acc_q <= 1'b0;
                    end
                end
                WR_P0: orig_q <= bus.i_reg_rdata;
                WR_P1: if (bus.i_reg_rdata != BIST_PAT0) err_acc_q <= 1'b1;
                RESTORE: begin
                    if (!i_bist_en || abort_q)           err_acc_q <= 1'b0;
                    else if (bus.i_reg_rdata != BIST_PAT1) err_acc_q <= 1'b1;
                end
                ACK: begin
                    err_acc_q <= 1'b0;
                    if (i_bist_en) ptr_q <= ptr_q + PTR_W'(1);
                end
                default: ;
            endcase
            if (abort_now) abort_q <= 1'b1;
        end
    end

    always_comb begin
        wdata_d = '0;
        case (state_q)
            WR_P0:   wdata_d = BIST_PAT0;
            WR_P1:   wdata_d = BIST_PAT1;
            RESTORE: wdata_d = orig_q;
            default: ;
        endcase
    end

    assign o_bist_busy             = (state_q != IDLE);
    assign o_bist_done             = (ptr_q == PTR_END);
    assign bus.o_reg_rd_en         = state_q inside {RD_ORIG, RD_P0, RD_P1};
    assign bus.o_reg_wr_en         = state_q inside {WR_P0, WR_P1, RESTORE};
    assign bus.o_reg_wdata         = wdata_d;
    assign bus.o_reg_addr          = (state_q != IDLE) ? SCAN_BASE_ADDR + REG_AW'(ptr_q) : '0;
    assign bus.o_scan_reg_bist_ack = (state_q == ACK) && i_bist_en;
    assign bus.o_scan_reg_bist_err = (state_q == ACK) && i_bist_en && err_acc_q;

endmodule

// File: tb/tb_lv_scan_reg_bist.sv
// Bench for lv_scan_reg_bist: register-file model with stuck-at cells, table-driven and
// randomized register sets, plus abort, done, async-reset and back-to-back sequences.
module tb_lv_scan_reg_bist;
    import lv_bist_pkg::*;

    typedef struct {
        logic [7:0] preload;
        logic [7:0] s1;
        logic [7:0] s0;
        logic       exp_err;
        logic [7:0] exp_final;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic busy, done;

    lv_scan_reg_bist_if bus ();

    lv_scan_reg_bist dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_bist_en   (en),
        .o_bist_busy (busy),
        .o_bist_done (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Register file: a stuck cell reads back (value & ~s0) | s1.
    logic [7:0] mem [256];
    logic [7:0] pre [256];
    logic [7:0] s1  [256];
    logic [7:0] s0  [256];
    logic       load = 1'b0;

    function automatic logic [7:0] stuck_rd(input logic [7:0] v, input logic [7:0] one, input logic [7:0] zero);
        return (v & ~zero) | one;
    endfunction

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= pre[i];
        end else if (bus.o_reg_wr_en) begin
            mem[bus.o_reg_addr] <= bus.o_reg_wdata;
        end
        if (bus.o_reg_rd_en) bus.i_reg_rdata <= stuck_rd(mem[bus.o_reg_addr], s1[bus.o_reg_addr], s0[bus.o_reg_addr]);
    end

    // Bus activity monitor, sampled mid-cycle.
    int         ack_cnt = 0, wr_cnt = 0, rd_cnt = 0, busy_cnt = 0, dup_cnt = 0;
    logic       prev_ack = 1'b0;
    logic [7:0] last_wr_addr = '0, last_wr_data = '0;

    always @(negedge clk) begin
        if (bus.o_scan_reg_bist_ack) ack_cnt <= ack_cnt + 1;
        if (bus.o_scan_reg_bist_ack && prev_ack) dup_cnt <= dup_cnt + 1;
        prev_ack <= bus.o_scan_reg_bist_ack;
        if (bus.o_reg_rd_en) rd_cnt <= rd_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (bus.o_reg_wr_en) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= bus.o_reg_addr;
            last_wr_data <= bus.o_reg_wdata;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t       tab_good [8];
    vec_t       tab_stuck[8];
    vec_t       cur      [8];
    logic [7:0] rb       [8];

    logic       acked, err_o;
    int         lat, nack, last_n, w0, a0, r0, b0;
    logic [7:0] first_rd, rst_rd;

    function automatic logic model_err(input logic [7:0] one, input logic [7:0] zero);
        return (stuck_rd(BIST_PAT0, one, zero) != BIST_PAT0) || (stuck_rd(BIST_PAT1, one, zero) != BIST_PAT1);
    endfunction

    task automatic load_cur();
        for (int k = 0; k < 8; k++) begin
            pre[SCAN_BASE_ADDR + 8'(k)] = cur[k].preload;
            s1 [SCAN_BASE_ADDR + 8'(k)] = cur[k].s1;
            s0 [SCAN_BASE_ADDR + 8'(k)] = cur[k].s0;
        end
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
    endtask

    task automatic clear_ptr();
        @(posedge clk); #1 en = 1'b0;
        @(posedge clk); #1 en = 1'b1;
    endtask

    // One request; n counts mid-cycle samples from the IDLE cycle that sees req (n=0).
    task automatic run_one(output logic a, output logic e, output int l,
                           output logic [7:0] frd, output logic [7:0] rrd);
        int   nwr;
        logic got_rd;
        a = 1'b0; e = 1'b0; l = -1; frd = '0; rrd = '0; nwr = 0; got_rd = 1'b0;
        @(posedge clk); #1 bus.i_bist_scan_reg_req = 1'b1;
        for (int n = 0; n < 20 && !a; n++) begin
            @(negedge clk);
            if (bus.o_reg_rd_en && !got_rd) begin
                got_rd = 1'b1;
                frd    = bus.o_reg_addr;
            end
            if (bus.o_reg_wr_en) begin
                nwr++;
                if (nwr == 3) rrd = bus.i_reg_rdata;
            end
            if (bus.o_scan_reg_bist_ack) begin
                a = 1'b1;
                l = n;
                e = bus.o_scan_reg_bist_err;
            end
        end
        @(posedge clk); #1 bus.i_bist_scan_reg_req = 1'b0;
    endtask

    task automatic run_set(input string tag);
        load_cur();
        for (int k = 0; k < 8; k++) begin
            run_one(acked, err_o, lat, first_rd, rst_rd);
            check($sformatf("%s ack idx%0d", tag, k), acked, 1);
            check($sformatf("%s latency idx%0d", tag, k), lat, 7);
            check($sformatf("%s err idx%0d", tag, k), err_o, cur[k].exp_err);
            check($sformatf("%s addr idx%0d", tag, k), first_rd, SCAN_BASE_ADDR + 8'(k));
            rb[k] = rst_rd;
        end
        check($sformatf("%s done", tag), done, 1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s final idx%0d", tag, k),
                  stuck_rd(mem[SCAN_BASE_ADDR + 8'(k)], s1[SCAN_BASE_ADDR + 8'(k)], s0[SCAN_BASE_ADDR + 8'(k)]),
                  cur[k].exp_final);
        end
    endtask

    initial begin
        tab_good[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
        tab_good[1] = '{8'h11, 8'h00, 8'h00, 1'b0, 8'h11};
        tab_good[2] = '{8'hA5, 8'h00, 8'h00, 1'b0, 8'hA5};
        tab_good[3] = '{8'h3C, 8'h00, 8'h00, 1'b0, 8'h3C};
        tab_good[4] = '{8'hFF, 8'h00, 8'h00, 1'b0, 8'hFF};
        tab_good[5] = '{8'h55, 8'h00, 8'h00, 1'b0, 8'h55};
        tab_good[6] = '{8'hAA, 8'h00, 8'h00, 1'b0, 8'hAA};
        tab_good[7] = '{8'h7E, 8'h00, 8'h00, 1'b0, 8'h7E};
        tab_stuck    = tab_good;
        tab_stuck[2] = '{8'hA5, 8'h01, 8'h00, 1'b1, 8'hA5};

        for (int i = 0; i < 256; i++) begin
            pre[i] = 8'(i); s1[i] = '0; s0[i] = '0;
        end
        bus.i_bist_scan_reg_req = 1'b0;

        repeat (3) @(posedge clk);
        #1 check("reset outputs",
                 {busy, done, bus.o_scan_reg_bist_ack, bus.o_scan_reg_bist_err, bus.o_reg_rd_en,
                  bus.o_reg_wr_en, bus.o_reg_addr, bus.o_reg_wdata}, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        @(posedge clk); #1;

        cur = tab_good;
        run_set("good");

        clear_ptr();
        check("done cleared by en low", done, 0);
        cur = tab_stuck;
        run_set("stuck");
        check("stuck idx2 RD_P1 readback", rb[2], 8'hAB);

        for (int r = 0; r < 3; r++) begin
            clear_ptr();
            for (int k = 0; k < 8; k++) begin
                cur[k].preload   = 8'($urandom);
                cur[k].s1        = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
                cur[k].s0        = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
                cur[k].exp_err   = model_err(cur[k].s1, cur[k].s0);
                cur[k].exp_final = stuck_rd(cur[k].preload, cur[k].s1, cur[k].s0);
            end
            run_set($sformatf("rand%0d", r));
        end

        // Abort during RD_P0 of idx1.
        clear_ptr();
        cur = tab_good;
        load_cur();
        run_one(acked, err_o, lat, first_rd, rst_rd);
        check("abort pre idx0 ack", acked, 1);
        @(posedge clk); #1 bus.i_bist_scan_reg_req = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("abort in RD_P0", {bus.o_reg_rd_en, bus.o_reg_addr}, {1'b1, 8'h41});
        w0 = wr_cnt; a0 = ack_cnt;
        en = 1'b0; bus.i_bist_scan_reg_req = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("abort write count", wr_cnt - w0, 1);
        check("abort restore addr", last_wr_addr, 8'h41);
        check("abort restore data", last_wr_data, 8'h11);
        check("abort no ack", ack_cnt - a0, 0);
        check("abort busy", busy, 0);
        check("abort reg value", mem[8'h41], 8'h11);
        en = 1'b1;
        run_one(acked, err_o, lat, first_rd, rst_rd);
        check("after abort ack", acked, 1);
        check("after abort restarts at idx0", first_rd, 8'h40);

        // Back-to-back with req held high, then requests at done.
        clear_ptr();
        load_cur();
        @(posedge clk); #1 bus.i_bist_scan_reg_req = 1'b1;
        nack = 0; last_n = 0;
        for (int n = 0; n < 120 && nack < 8; n++) begin
            @(negedge clk);
            if (bus.o_scan_reg_bist_ack) begin
                check($sformatf("b2b addr ack%0d", nack), bus.o_reg_addr, SCAN_BASE_ADDR + 8'(nack));
                if (nack == 0) check("b2b first latency", n, 7);
                else           check($sformatf("b2b spacing ack%0d", nack), n - last_n, 8);
                last_n = n;
                nack++;
            end
        end
        check("b2b ack count", nack, 8);
        @(posedge clk); #1 check("b2b done", done, 1);
        r0 = rd_cnt; w0 = wr_cnt; a0 = ack_cnt; b0 = busy_cnt;
        repeat (20) @(posedge clk);
        #1 check("done no reads", rd_cnt - r0, 0);
        check("done no writes", wr_cnt - w0, 0);
        check("done no acks", ack_cnt - a0, 0);
        check("done never busy", busy_cnt - b0, 0);
        bus.i_bist_scan_reg_req = 1'b0;

        // Async reset during WR_P1.
        clear_ptr();
        load_cur();
        @(posedge clk); #1 bus.i_bist_scan_reg_req = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("reset pre WR_P1", {bus.o_reg_wr_en, bus.o_reg_wdata}, {1'b1, 8'hAA});
        rst_n = 1'b0;
        #1 check("async reset outputs",
                 {busy, done, bus.o_scan_reg_bist_ack, bus.o_scan_reg_bist_err, bus.o_reg_rd_en,
                  bus.o_reg_wr_en, bus.o_reg_addr, bus.o_reg_wdata}, 0);
        bus.i_bist_scan_reg_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        load_cur();
        run_one(acked, err_o, lat, first_rd, rst_rd);
        check("post reset ack", acked, 1);
        check("post reset latency", lat, 7);
        check("post reset idx0", first_rd, 8'h40);

        check("no back-to-back duplicate ack", dup_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
